// File: rtl/mig_burst_dma_pkg.sv
// Shared types and helpers for the MIG burst DMA.
// Optional statistics build: define MIG_BURST_DMA_STATS_EN.
package mig_burst_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_FILL,
    WR_CMD,
    RD_CMD,
    RD_DRAIN
  } state_t;

  localparam logic [2:0] MIG_WR = 3'b000;
  localparam logic [2:0] MIG_RD = 3'b001;

  // Burst word counters; wide enough for BURST_LEN up to 64.
  localparam int unsigned BL_CW = 7;

  function automatic logic [29:0] burst_addr(
    input logic [31:0] ptr,
    input logic [31:0] blen,
    input logic [31:0] dw
  );
    logic [31:0] a;
    a = ptr * blen * (dw >> 3);
    return a[29:0];
  endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Two-request round-robin arbiter for write/read bursts.
// After reset the write side wins the first tie.
module dma_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic req_w,
  input  logic req_r,
  input  logic take,
  output logic gnt_w,
  output logic gnt_r
);

  logic last_w;

  always_comb begin
    gnt_w = req_w & (~req_r | ~last_w);
    gnt_r = req_r & (~req_w | last_w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_w <= 1'b0;
    end else if (take & (gnt_w | gnt_r)) begin
      last_w <= gnt_w;
    end
  end

endmodule

// File: rtl/mig_burst_dma.sv
// Burst DMA: inbound FIFO -> DDR ring via MIG -> outbound FIFO.
// Define MIG_BURST_DMA_STATS_EN for burst counters and overrun flag.
module mig_burst_dma
  import mig_burst_dma_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int BURST_LEN     = 32,
  parameter int CNT_W         = 10,
  parameter int OB_DEPTH      = 1023,
  parameter int REGION_BURSTS = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reads_en,
  input  logic                  writes_en,
  input  logic                  calib_done,
  output logic                  ib_re,
  input  logic [DATA_W-1:0]     ib_data,
  input  logic [CNT_W-1:0]      ib_count,
  input  logic                  ib_valid,
  input  logic                  ib_empty,
  output logic                  ob_we,
  output logic [DATA_W-1:0]     ob_data,
  input  logic [CNT_W-1:0]      ob_count,
  output logic                  cmd_en,
  output logic [2:0]            cmd_instr,
  output logic [29:0]           cmd_byte_addr,
  output logic [5:0]            cmd_bl_o,
  input  logic                  cmd_full,
  output logic                  wr_en,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_mask,
  input  logic                  wr_full,
  output logic                  rd_en_o,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  rd_empty,
  output logic                  busy,
  output logic [$clog2(REGION_BURSTS):0] level
`ifdef MIG_BURST_DMA_STATS_EN
  ,
  output logic [31:0]           wr_bursts,
  output logic [31:0]           rd_bursts,
  output logic                  overrun
`endif
);

  localparam int LVL_W = $clog2(REGION_BURSTS) + 1;
  localparam int PTR_W = (REGION_BURSTS > 1) ? $clog2(REGION_BURSTS) : 1;
  localparam logic [BL_CW-1:0] BL = BL_CW'(BURST_LEN);

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [BL_CW-1:0]   req_cnt;
  logic [BL_CW-1:0]   done_cnt;

  logic wr_elig;
  logic rd_elig;
  logic take;
  logic gnt_w;
  logic gnt_r;
  logic in_fill;
  logic in_wcmd;
  logic in_rcmd;

  assign wr_elig = writes_en
                 & (ib_count >= CNT_W'(BURST_LEN))
                 & (level < LVL_W'(REGION_BURSTS));
  assign rd_elig = reads_en
                 & (level != '0)
                 & (ob_count <= CNT_W'(OB_DEPTH - BURST_LEN));
  assign take = (state == IDLE) & calib_done;

  dma_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .req_w (wr_elig),
    .req_r (rd_elig),
    .take  (take),
    .gnt_w (gnt_w),
    .gnt_r (gnt_r)
  );

  assign in_fill = (state == WR_FILL);
  assign in_wcmd = (state == WR_CMD);
  assign in_rcmd = (state == RD_CMD);

  // Every output is gated by state so IDLE (and reset) drives zeros.
  always_comb begin
    ib_re         = in_fill & (req_cnt < BL) & ~wr_full & ~ib_empty;
    wr_en         = in_fill & ib_valid;
    wr_data       = in_fill ? ib_data : '0;
    wr_mask       = '0;
    cmd_en        = (in_wcmd | in_rcmd) & ~cmd_full;
    cmd_instr     = in_rcmd ? MIG_RD : MIG_WR;
    cmd_bl_o      = (in_wcmd | in_rcmd) ? 6'(BURST_LEN - 1) : 6'd0;
    cmd_byte_addr = '0;
    if (in_wcmd)
      cmd_byte_addr = burst_addr(32'(wr_ptr), 32'(BURST_LEN), 32'(DATA_W));
    else if (in_rcmd)
      cmd_byte_addr = burst_addr(32'(rd_ptr), 32'(BURST_LEN), 32'(DATA_W));
    rd_en_o       = (state == RD_DRAIN) & (req_cnt < BL) & ~rd_empty;
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      req_cnt  <= '0;
      done_cnt <= '0;
      ob_we    <= 1'b0;
      ob_data  <= '0;
    end else begin
      ob_we <= rd_en_o;
      if (rd_en_o)
        ob_data <= rd_data;
      unique case (state)
        IDLE: begin
          req_cnt  <= '0;
          done_cnt <= '0;
          if (take & gnt_w)
            state <= WR_FILL;
          else if (take & gnt_r)
            state <= RD_CMD;
        end
        WR_FILL: begin
          if (ib_re)
            req_cnt <= req_cnt + 1'b1;
          if (wr_en) begin
            if (done_cnt == BL - 1'b1) begin
              done_cnt <= '0;
              state    <= WR_CMD;
            end else begin
              done_cnt <= done_cnt + 1'b1;
            end
          end
        end
        WR_CMD: begin
          if (~cmd_full) begin
            wr_ptr <= wr_ptr + 1'b1;
            level  <= level + 1'b1;
            state  <= IDLE;
          end
        end
        RD_CMD: begin
          if (~cmd_full) begin
            rd_ptr <= rd_ptr + 1'b1;
            level  <= level - 1'b1;
            state  <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (rd_en_o)
            req_cnt <= req_cnt + 1'b1;
          // Stay until the last word has reached the outbound FIFO.
          if (ob_we) begin
            if (done_cnt == BL - 1'b1)
              state <= IDLE;
            else
              done_cnt <= done_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIG_BURST_DMA_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bursts <= '0;
      rd_bursts <= '0;
      overrun   <= 1'b0;
    end else begin
      if (cmd_en & in_wcmd & (wr_bursts != '1))
        wr_bursts <= wr_bursts + 1'b1;
      if (cmd_en & in_rcmd & (rd_bursts != '1))
        rd_bursts <= rd_bursts + 1'b1;
      if (ib_valid & ~in_fill)
        overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mig_burst_dma.sv
// Directed bench for mig_burst_dma with FIFO and MIG models.
// Uses a 4-burst ring so wrap and full-ring blocking are reachable.
module tb_mig_burst_dma;

  localparam int DW  = 32;
  localparam int BL  = 32;
  localparam int CW  = 10;
  localparam int OBD = 1023;
  localparam int RB  = 4;

  logic clk = 1'b0;
  logic reset;
  logic reads_en, writes_en, calib_done;
  logic ib_re, ib_valid, ib_empty;
  logic [DW-1:0] ib_data;
  logic [CW-1:0] ib_count, ob_count;
  logic ob_we;
  logic [DW-1:0] ob_data;
  logic cmd_en, cmd_full;
  logic [2:0] cmd_instr;
  logic [29:0] cmd_byte_addr;
  logic [5:0] cmd_bl_o;
  logic wr_en, wr_full, rd_en_o, rd_empty;
  logic [DW-1:0] wr_data, rd_data;
  logic [DW/8-1:0] wr_mask;
  logic busy;
  logic [2:0] level;
`ifdef MIG_BURST_DMA_STATS_EN
  logic [31:0] wr_bursts, rd_bursts;
  logic overrun;
`endif

  always #5 clk = ~clk;

  mig_burst_dma #(
    .DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW),
    .OB_DEPTH(OBD), .REGION_BURSTS(RB)
  ) u_dut (
    .clk(clk), .reset(reset),
    .reads_en(reads_en), .writes_en(writes_en),
    .calib_done(calib_done),
    .ib_re(ib_re), .ib_data(ib_data), .ib_count(ib_count),
    .ib_valid(ib_valid), .ib_empty(ib_empty),
    .ob_we(ob_we), .ob_data(ob_data), .ob_count(ob_count),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr),
    .cmd_byte_addr(cmd_byte_addr), .cmd_bl_o(cmd_bl_o),
    .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_full(wr_full),
    .rd_en_o(rd_en_o), .rd_data(rd_data), .rd_empty(rd_empty),
    .busy(busy), .level(level)
`ifdef MIG_BURST_DMA_STATS_EN
    , .wr_bursts(wr_bursts), .rd_bursts(rd_bursts), .overrun(overrun)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Models: inbound FIFO, MIG write/read FIFOs + memory, outbound sink
  int cyc = 0;
  int load_tgt = 0;
  int pushed = 0;
  int re_total = 0;
  int wr_total = 0;
  int max_level = 0;
  logic stall_en = 1'b0;
  logic rd_emp_q = 1'b1;
  logic [31:0] ibq[$];
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic [31:0] obq[$];
  logic [31:0] mem [0:511];
  logic [2:0]  log_instr[$];
  logic [29:0] log_addr[$];
  logic [5:0]  log_bl[$];

  assign cmd_full = stall_en & ((cyc % 3) == 0);
  assign wr_full  = stall_en & ((cyc % 5) == 2);
  assign rd_empty = rd_emp_q | (stall_en & ((cyc % 4) == 1));

  initial begin
    ib_data  = '0;
    ib_valid = 1'b0;
    ib_count = '0;
    ib_empty = 1'b1;
    rd_data  = '0;
  end

  always @(posedge clk) begin
    int idx;
    cyc <= cyc + 1;
    if (ib_re && ibq.size() > 0) begin
      ib_data  <= ibq.pop_front();
      ib_valid <= 1'b1;
    end else begin
      ib_valid <= 1'b0;
    end
    while (pushed < load_tgt) begin
      ibq.push_back(word(pushed));
      pushed++;
    end
    ib_count <= (ibq.size() > 1023) ? 10'd1023 : 10'(ibq.size());
    ib_empty <= (ibq.size() == 0);
    if (ib_re) re_total++;
    if (wr_en) begin
      wr_total++;
      wq.push_back(wr_data);
    end
    if (rd_en_o && rq.size() > 0) void'(rq.pop_front());
    if (cmd_en) begin
      log_instr.push_back(cmd_instr);
      log_addr.push_back(cmd_byte_addr);
      log_bl.push_back(cmd_bl_o);
      idx = int'(cmd_byte_addr >> 2);
      for (int i = 0; i < BL; i++) begin
        if (cmd_instr == 3'b000)
          mem[(idx + i) % 512] = (wq.size() > 0) ? wq.pop_front() : 32'hDEAD;
        else
          rq.push_back(mem[(idx + i) % 512]);
      end
    end
    rd_emp_q <= (rq.size() == 0);
    rd_data  <= (rq.size() > 0) ? rq[0] : 32'h0;
    if (ob_we) obq.push_back(ob_data);
    if (int'(level) > max_level) max_level = int'(level);
  end

  task automatic wait_quiet(string tag, int budget);
    int q = 0;
    int t = 0;
    while (q < 8 && t < budget) begin
      @(negedge clk);
      t++;
      q = busy ? 0 : q + 1;
    end
    check(tag, q >= 8, 1);
  endtask

  task automatic wait_log(string tag, int n, int budget);
    int t = 0;
    while (log_instr.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, log_instr.size() >= n, 1);
  endtask

  initial begin
    int n0, r0, w0, nbad;
    logic [29:0] exp_a [4];
    reset      = 1'b1;
    reads_en   = 1'b0;
    writes_en  = 1'b0;
    calib_done = 1'b0;
    ob_count   = '0;
    repeat (3) @(negedge clk);
    check("rst_outs",
          {busy, ib_re, cmd_en, ob_we, wr_en, rd_en_o, level}, 0);
    reset = 1'b0;

    // No calibration: nothing moves
    writes_en = 1'b1;
    load_tgt  = 64;
    r0 = re_total;
    n0 = log_instr.size();
    repeat (100) @(negedge clk);
    check("nocal_cmd", log_instr.size() - n0, 0);
    check("nocal_re", re_total - r0, 0);
    check("nocal_busy", busy, 0);

    // Two write bursts
    calib_done = 1'b1;
    wait_quiet("wr2_done", 2000);
    check("wr2_ncmd", log_instr.size(), 2);
    check("wr2_instr", {log_instr[0], log_instr[1]}, 6'b000_000);
    check("wr2_addr0", log_addr[0], 30'h000);
    check("wr2_addr1", log_addr[1], 30'h080);
    check("wr2_bl", {log_bl[0], log_bl[1]}, {6'd31, 6'd31});
    check("wr2_level", level, 2);
    check("wr2_ib_empty", ib_empty, 1);

    // Two read bursts
    writes_en = 1'b0;
    reads_en  = 1'b1;
    wait_quiet("rd2_done", 2000);
    check("rd2_ncmd", log_instr.size(), 4);
    check("rd2_instr", {log_instr[2], log_instr[3]}, 6'b001_001);
    check("rd2_addr0", log_addr[2], 30'h000);
    check("rd2_addr1", log_addr[3], 30'h080);
    check("rd2_nob", obq.size(), 64);
    check("rd2_w0", obq[0], word(0));
    check("rd2_w63", obq[63], word(63));
    check("rd2_level", level, 0);

    // Both enabled with stalls: W,R alternation, pointers wrap
    stall_en  = 1'b1;
    writes_en = 1'b1;
    load_tgt += 128;
    n0 = log_instr.size();
    wait_quiet("rr_done", 6000);
    check("rr_ncmd", log_instr.size() - n0, 8);
    exp_a = '{30'h100, 30'h180, 30'h000, 30'h080};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_w%0d_instr", k), log_instr[n0 + 2*k], 3'b000);
      check($sformatf("rr_r%0d_instr", k), log_instr[n0 + 2*k + 1], 3'b001);
      check($sformatf("rr_w%0d_addr", k), log_addr[n0 + 2*k], exp_a[k]);
      check($sformatf("rr_r%0d_addr", k), log_addr[n0 + 2*k + 1], exp_a[k]);
    end
    check("rr_level", level, 0);
    check("rr_nob", obq.size(), 192);
    stall_en = 1'b0;

    // Fill the ring and confirm writes block at level 4
    reads_en  = 1'b0;
    load_tgt += 192;
    n0 = log_instr.size();
    wait_quiet("fill_done", 3000);
    check("fill_ncmd", log_instr.size() - n0, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("fill_addr%0d", k), log_addr[n0 + k], exp_a[k]);
    check("fill_level", level, 4);
    r0 = re_total;
    n0 = log_instr.size();
    repeat (100) @(negedge clk);
    check("full_block_cmd", log_instr.size() - n0, 0);
    check("full_block_re", re_total - r0, 0);
    check("full_ib_count", ib_count, 64);

    // Outbound space boundary, then abort request mid-burst
    writes_en = 1'b0;
    ob_count  = 10'd992;
    reads_en  = 1'b1;
    repeat (60) @(negedge clk);
    check("ob_block", log_instr.size() - n0, 0);
    ob_count = 10'd991;
    wait_log("ob_edge_rd", n0 + 1, 200);
    reads_en = 1'b0;
    ob_count = '0;
    check("ob_edge_addr", log_addr[log_instr.size() - 1], 30'h100);
    wait_quiet("abort_done", 1000);
    check("abort_ncmd", log_instr.size() - n0, 1);
    check("abort_level", level, 3);
    check("abort_nob", obq.size(), 224);

    // Last grant was read: a tie now goes to write
    n0 = log_instr.size();
    writes_en = 1'b1;
    reads_en  = 1'b1;
    wait_log("tie_cmds", n0 + 2, 1000);
    writes_en = 1'b0;
    check("tie_first_w", log_instr[n0], 3'b000);
    check("tie_second_r", log_instr[n0 + 1], 3'b001);
    wait_quiet("drain_done", 4000);
    check("drain_level", level, 0);
    check("max_level", max_level, 4);
    check("stream_len", obq.size(), 352);
    nbad = 0;
    for (int i = 0; i < obq.size(); i++)
      if (obq[i] !== word(i)) nbad++;
    check("stream_bad", nbad, 0);

    // Reset in the middle of a write fill
    reads_en  = 1'b0;
    load_tgt += 32;
    w0 = wr_total;
    writes_en = 1'b1;
    begin
      int t = 0;
      while (wr_total - w0 < 10 && t < 500) begin
        @(negedge clk);
        t++;
      end
      check("mid_fill_reached", wr_total - w0 >= 10, 1);
    end
    check("mid_fill_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("rst_async_outs",
          {busy, ib_re, cmd_en, ob_we, wr_en, rd_en_o, level}, 0);
    @(negedge clk);
    check("rst_next_outs",
          {busy, ib_re, cmd_en, ob_we, wr_en, rd_en_o, level}, 0);
    reset = 1'b0;
    n0 = log_instr.size();
    wait_log("post_rst_wr", n0 + 1, 1000);
    check("post_rst_addr", log_addr[n0], 30'h000);
    wait_quiet("post_rst_done", 1000);
    check("post_rst_level", level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
